apb_reg_completer: RTL

APB completer (responder) with a configurable register bank. It answers the transfers issued by the team's APB initiator and supports programmable wait states, byte-lane write strobes, PSLVERR-style error responses and clean abort when the initiator drops select. It sits on the peripheral side of the APB segment and exposes a read-only ID register plus a transfer/error statistics register to software.

---
 rtl/apb_pkg.sv | 8 +
 rtl/apb_reg_completer_if.sv | 18 +
 rtl/apb_reg_completer_reg_file.sv | 41 ++++
 rtl/apb_reg_completer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register completer.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [5:0]  ID_IDX       = 6'd0;
  localparam logic [5:0]  STAT_IDX     = 6'd1;
  localparam logic [31:0] ID_VALUE_DEF = 32'hA9B0_0001;
endpackage

// File: rtl/apb_reg_completer_if.sv
// APB segment signals between the initiator and this completer.
interface apb_reg_completer_if #(parameter int WAIT_W = 4);
  logic              apb_selx;
  logic              apb_en;
  logic              apb_write;
  logic [7:0]        apb_addr;
  logic [31:0]       apb_wdata;
  logic [3:0]        apb_strb;
  logic [WAIT_W-1:0] wait_cycle;
  logic [31:0]       apb_rdata;
  logic              apb_ready;
  logic              apb_slverr;

  modport master (output apb_selx, apb_en, apb_write, apb_addr, apb_wdata, apb_strb, wait_cycle,
                  input  apb_rdata, apb_ready, apb_slverr);
  modport slave  (input  apb_selx, apb_en, apb_write, apb_addr, apb_wdata, apb_strb, wait_cycle,
                  output apb_rdata, apb_ready, apb_slverr);
endinterface

// File: rtl/apb_reg_completer_reg_file.sv
// Word register storage: one strobed write port, one combinational read port.
module apb_reg_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        apb_clk,
  input  logic        sys_reset,
  input  logic [5:0]  rd_idx,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic [5:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb
);
  logic [NUM_REGS-1:0][31:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == 6'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem_d[i][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Out-of-range indices read as zero; the top flags them as errors anyway.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 6'(i)) rd_data = mem_q[i];
    end
  end

  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) mem_q <= '0;
    else            mem_q <= mem_d;
  end
endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: wait-state FSM, error decode, ID/STAT registers and statistics counters.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 32,
  parameter int          WAIT_W   = 4,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
  input logic               apb_clk,
  input logic               sys_reset,
  apb_reg_completer_if.slave bus
);
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [5:0]        idx_q, idx_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              slverr_q, slverr_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [5:0]  cur_idx, rd_idx;
  logic [31:0] rf_rdata, rd_val;
  logic        setup_err, complete, rf_we;

  assign cur_idx   = bus.apb_addr[7:2];
  assign setup_err = (bus.apb_addr[1:0] != 2'b00) || (int'(cur_idx) >= NUM_REGS) ||
                     (bus.apb_write && (cur_idx <= STAT_IDX));
  // With no wait states the read data must come from the live address at setup.
  assign rd_idx    = (state_q == IDLE) ? cur_idx : idx_q;
  assign rf_we     = complete && write_q && !err_q;

  always_comb begin
    case (rd_idx)
      ID_IDX:   rd_val = ID_VALUE;
      STAT_IDX: rd_val = {err_count_q, wr_count_q};
      default:  rd_val = rf_rdata;
    endcase
  end

  apb_reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .apb_clk (apb_clk),
    .sys_reset(sys_reset),
    .rd_idx  (rd_idx),
    .rd_data (rf_rdata),
    .we      (rf_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    slverr_d    = slverr_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    complete    = 1'b0;
    case (state_q)
      IDLE: if (bus.apb_selx) begin
        idx_d   = cur_idx;
        write_d = bus.apb_write;
        wdata_d = bus.apb_wdata;
        strb_d  = bus.apb_strb;
        err_d   = setup_err;
        if (bus.wait_cycle == '0) begin
          state_d  = RESP;
          slverr_d = setup_err;
          rdata_d  = (setup_err || bus.apb_write) ? '0 : rd_val;
        end else begin
          cnt_d   = bus.wait_cycle;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.apb_selx) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_W'(1)) begin
          state_d  = RESP;
          slverr_d = err_q;
          rdata_d  = (err_q || write_q) ? '0 : rd_val;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      RESP: if (!bus.apb_selx || bus.apb_en) begin
        // Dropped select aborts without side effects; otherwise this edge completes.
        state_d  = IDLE;
        rdata_d  = '0;
        slverr_d = 1'b0;
        complete = bus.apb_selx;
      end
      default: state_d = IDLE;
    endcase
    if (complete && err_q && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
    if (complete && !err_q && write_q && (wr_count_q != 16'hFFFF))
      wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      slverr_q    <= slverr_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.apb_ready  = (state_q == RESP);
  assign bus.apb_rdata  = rdata_q;
  assign bus.apb_slverr = slverr_q;
endmodule
